// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_MADD_EN to also accept the SPECIAL2 madd/maddu/msub accumulate ops.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    output logic        out_start,
    output logic        out_busy,
    output logic [31:0] out_hilo,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo
);

    typedef enum logic [3:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MFHI,
        OP_MTHI,
        OP_MFLO,
        OP_MTLO,
        OP_MADD,
        OP_MADDU,
        OP_MSUB
    } op_e;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
    localparam logic [3:0] MULT_CNT     = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT      = 4'(DIV_CYCLES);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rhi_q, rhi_d;
    logic [31:0] rlo_q, rlo_d;
    logic [3:0]  cnt_q, cnt_d;

    op_e         op;
    logic        is_multi;
    logic        is_div;

    // Register-field bits are irrelevant to decode.
    logic unused_instr_bits;
    assign unused_instr_bits = ^in_instr[25:6];

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        op = OP_NONE;
        if (in_instr[31:26] == OPC_SPECIAL) begin
            case (in_instr[5:0])
                6'h18:   op = OP_MULT;
                6'h19:   op = OP_MULTU;
                6'h1A:   op = OP_DIV;
                6'h1B:   op = OP_DIVU;
                6'h10:   op = OP_MFHI;
                6'h11:   op = OP_MTHI;
                6'h12:   op = OP_MFLO;
                6'h13:   op = OP_MTLO;
                default: op = OP_NONE;
            endcase
        end
`ifdef MDU_MADD_EN
        else if (in_instr[31:26] == OPC_SPECIAL2) begin
            case (in_instr[5:0])
                6'h00:   op = OP_MADD;
                6'h01:   op = OP_MADDU;
                6'h04:   op = OP_MSUB;
                default: op = OP_NONE;
            endcase
        end
`endif
    end

    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_multi  = is_div || (op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB});
    assign out_busy  = (cnt_q != 4'd0);
    assign out_start = is_multi && !out_busy;

    // Multiplier: extending to 64 b makes the truncated product correct for both signednesses.
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign mul_signed = op inside {OP_MULT, OP_MADD, OP_MSUB};
    assign mul_a      = mul_signed ? {{32{in_rs[31]}}, in_rs} : {32'd0, in_rs};
    assign mul_b      = mul_signed ? {{32{in_rt[31]}}, in_rt} : {32'd0, in_rt};
    assign product    = mul_a * mul_b;

    // Divider works on magnitudes; this also makes 0x80000000 / -1 wrap to 0x80000000.
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_quo;
    logic [31:0] mag_rem;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_by_zero;

    assign neg_a       = (op == OP_DIV) && in_rs[31];
    assign neg_b       = (op == OP_DIV) && in_rt[31];
    assign abs_a       = neg_a ? -in_rs : in_rs;
    assign abs_b       = neg_b ? -in_rt : in_rt;
    assign div_by_zero = (in_rt == 32'd0);
    assign mag_quo     = div_by_zero ? 32'd0 : abs_a / abs_b;
    assign mag_rem     = div_by_zero ? 32'd0 : abs_a % abs_b;
    assign div_quo     = (neg_a ^ neg_b) ? -mag_quo : mag_quo;
    assign div_rem     = neg_a ? -mag_rem : mag_rem;

    logic [63:0] result;

    always_comb begin
        result = {hi_q, lo_q};
        case (op)
            OP_MULT, OP_MULTU: result = product;
            OP_DIV, OP_DIVU:   result = div_by_zero ? {hi_q, lo_q} : {div_rem, div_quo};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: result = {hi_q, lo_q} + product;
            OP_MSUB:           result = {hi_q, lo_q} - product;
`endif
            default:           result = {hi_q, lo_q};
        endcase
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        rhi_d = rhi_q;
        rlo_d = rlo_q;
        cnt_d = cnt_q;
        if (out_start) begin
            rhi_d = result[63:32];
            rlo_d = result[31:0];
            cnt_d = is_div ? DIV_CNT : MULT_CNT;
        end else if (out_busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d = rhi_q;
                lo_d = rlo_q;
            end
        end else if (op == OP_MTHI) begin
            hi_d = in_rs;
        end else if (op == OP_MTLO) begin
            lo_d = in_rs;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the result shadows are cleared too, so a reset mid-operation cannot leak a stale result.
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            rhi_q <= 32'd0;
            rlo_q <= 32'd0;
            cnt_q <= 4'd0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            rhi_q <= rhi_d;
            rlo_q <= rlo_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_hi   = hi_q;
    assign out_lo   = lo_q;
    assign out_hilo = (op == OP_MFHI) ? hi_q :
                      (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed spec cases plus randomized ops against an arithmetic model.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_instr;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic        out_start;
    logic        out_busy;
    logic [31:0] out_hilo;
    logic [31:0] out_hi;
    logic [31:0] out_lo;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_instr (in_instr),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .out_start(out_start),
        .out_busy (out_busy),
        .out_hilo (out_hilo),
        .out_hi   (out_hi),
        .out_lo   (out_lo)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic logic [31:0] special(input logic [5:0] f);
        logic [19:0] fields;
        fields = 20'($urandom);
        return {6'h00, fields, f};
    endfunction

    function automatic int exp_cycles(input logic [5:0] f);
        if (f == F_MULT || f == F_MULTU) return 5;
        if (f == F_DIV || f == F_DIVU) return 10;
        return 0;
    endfunction

    // Architectural model: plain 64-bit integer arithmetic on the spec's rules.
    task automatic model_apply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] up;
        case (f)
            F_MULT: begin
                sa = $signed(a); sb = $signed(b); q = sa * sb;
                m_hi = q[63:32]; m_lo = q[31:0];
            end
            F_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            F_DIV: if (b != 0) begin
                sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
                m_hi = r[31:0]; m_lo = q[31:0];
            end
            F_DIVU: if (b != 0) begin
                m_hi = a % b; m_lo = a / b;
            end
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Drives one instruction for one accept edge, then measures the busy window.
    task automatic do_op(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                         output logic start_seen, output int busy_n, output logic held_ok,
                         output logic [31:0] hi_o, output logic [31:0] lo_o);
        @(negedge clk);
        in_instr = instr; in_rs = rs; in_rt = rt;
        #1 start_seen = out_start;
        @(posedge clk);
        #1 in_instr = 32'd0; in_rs = 32'd0; in_rt = 32'd0;
        busy_n = 0; held_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!out_busy) break;
            busy_n++;
            if (out_hi !== pre_hi || out_lo !== pre_lo) held_ok = 1'b0;
        end
        hi_o = out_hi; lo_o = out_lo;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_instr = 32'd0; in_rs = 32'd0; in_rt = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        in_instr = special(F_MFHI);
        #1;
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", out_busy); end
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", out_start); end
        checks++; if (out_hi !== 32'd0 || out_lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h:%h want 0:0", out_hi, out_lo); end
        checks++; if (out_hilo !== 32'd0) begin errors++; $display("FAIL reset_mfhi got %h want 0", out_hilo); end
        in_instr = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult();
        logic s, held; int n; logic [31:0] h, l;
        do_op(special(F_MULT), 32'hFFFF_FFFE, 32'd3, m_hi, m_lo, s, n, held, h, l);
        model_apply(F_MULT, 32'hFFFF_FFFE, 32'd3);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL mult_start got %b want 1", s); end
        checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hilo_held got %b want 1", held); end
        checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_result got %h:%h want ffffffff:fffffffa", h, l); end
    endtask

    task automatic test_div();
        logic [5:0]  f[3]  = '{F_DIVU, F_DIV, F_DIV};
        logic [31:0] a[3]  = '{32'd7, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] b[3]  = '{32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] eh[3] = '{32'd1, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] el[3] = '{32'd3, 32'hFFFF_FFFD, 32'h8000_0000};
        logic s, held; int n; logic [31:0] h, l;
        for (int i = 0; i < 3; i++) begin
            do_op(special(f[i]), a[i], b[i], m_hi, m_lo, s, n, held, h, l);
            model_apply(f[i], a[i], b[i]);
            checks++; if (n != 10) begin errors++; $display("FAIL div%0d_busy_cycles got %0d want 10", i, n); end
            checks++; if (h !== eh[i] || l !== el[i]) begin errors++; $display("FAIL div%0d_result got %h:%h want %h:%h", i, h, l, eh[i], el[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        logic s, held; int n; logic [31:0] h, l;
        do_op(special(F_MTHI), 32'h11, 32'd0, m_hi, m_lo, s, n, held, h, l);
        model_apply(F_MTHI, 32'h11, 32'd0);
        checks++; if (h !== 32'h11 || s !== 1'b0) begin errors++; $display("FAIL mthi got %h start %b want 11 start 0", h, s); end
        do_op(special(F_MTLO), 32'h22, 32'd0, m_hi, m_lo, s, n, held, h, l);
        model_apply(F_MTLO, 32'h22, 32'd0);
        checks++; if (l !== 32'h22) begin errors++; $display("FAIL mtlo got %h want 22", l); end
        do_op(special(F_DIV), 32'd5, 32'd0, m_hi, m_lo, s, n, held, h, l);
        checks++; if (n != 10) begin errors++; $display("FAIL divzero_busy_cycles got %0d want 10", n); end
        checks++; if (h !== 32'h11 || l !== 32'h22) begin errors++; $display("FAIL divzero_result got %h:%h want 11:22", h, l); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c, d;
        int n;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        @(negedge clk);
        in_instr = special(F_MULT); in_rs = a; in_rt = b;
        @(posedge clk);
        #1 in_instr = 32'd0;
        model_apply(F_MULT, a, b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!out_busy) break;
        end
        in_instr = special(F_MULTU); in_rs = c; in_rt = d;
        #1;
        checks++; if (out_start !== 1'b1) begin errors++; $display("FAIL b2b_start got %b want 1", out_start); end
        checks++; if (out_hi !== m_hi || out_lo !== m_lo) begin errors++; $display("FAIL b2b_first_result got %h:%h want %h:%h", out_hi, out_lo, m_hi, m_lo); end
        @(posedge clk);
        #1 in_instr = 32'd0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!out_busy) break;
            n++;
        end
        model_apply(F_MULTU, c, d);
        checks++; if (n != 5) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 5", n); end
        checks++; if (out_hi !== m_hi || out_lo !== m_lo) begin errors++; $display("FAIL b2b_second_result got %h:%h want %h:%h", out_hi, out_lo, m_hi, m_lo); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a, b, pre_hi;
        int n;
        a = $urandom; b = 32'($urandom_range(1, 1000));
        pre_hi = m_hi;
        @(negedge clk);
        in_instr = special(F_DIVU); in_rs = a; in_rt = b;
        @(posedge clk);
        #1 in_instr = 32'd0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!out_busy) break;
            n++;
            in_rs = 32'hDEAD_BEEF; in_rt = 32'd3;
            case (i)
                0: in_instr = special(F_MTHI);
                1: in_instr = special(F_MTLO);
                2: in_instr = special(F_MULT);
                3: in_instr = special(F_MFHI);
                default: in_instr = 32'd0;
            endcase
            #1;
            if (i == 2) begin
                checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL ignore_start got %b want 0", out_start); end
            end
            if (i == 3) begin
                checks++; if (out_hilo !== pre_hi) begin errors++; $display("FAIL ignore_mfhi_busy got %h want %h", out_hilo, pre_hi); end
            end
        end
        in_instr = 32'd0;
        model_apply(F_DIVU, a, b);
        checks++; if (n != 10) begin errors++; $display("FAIL ignore_busy_cycles got %0d want 10", n); end
        checks++; if (out_hi !== m_hi || out_lo !== m_lo) begin errors++; $display("FAIL ignore_result got %h:%h want %h:%h", out_hi, out_lo, m_hi, m_lo); end
    endtask

    task automatic test_mid_reset();
        logic s, held; int n; logic [31:0] h, l;
        do_op(special(F_MTHI), 32'h55, 32'd0, m_hi, m_lo, s, n, held, h, l);
        @(negedge clk);
        in_instr = special(F_MULTU); in_rs = 32'hFFFF_FFFF; in_rt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 in_instr = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", out_busy); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_after got %b want 0", out_busy); end
        checks++; if (out_hi !== 32'd0 || out_lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo got %h:%h want 0:0", out_hi, out_lo); end
        repeat (8) @(negedge clk);
        checks++; if (out_hi !== 32'd0 || out_lo !== 32'd0 || out_busy !== 1'b0) begin errors++; $display("FAIL midreset_late_commit got %h:%h busy %b want 0:0 busy 0", out_hi, out_lo, out_busy); end
    endtask

    task automatic test_madd();
        logic s, held; int n; logic [31:0] h, l;
        do_op(special(F_MTHI), 32'd0, 32'd0, m_hi, m_lo, s, n, held, h, l);
        do_op(special(F_MTLO), 32'd5, 32'd0, m_hi, m_lo, s, n, held, h, l);
        m_hi = 32'd0; m_lo = 32'd5;
        do_op({6'h1C, 20'd0, 6'h00}, 32'd2, 32'd3, m_hi, m_lo, s, n, held, h, l);
`ifdef MDU_MADD_EN
        checks++; if (s !== 1'b1 || n != 5) begin errors++; $display("FAIL madd_timing got start %b busy %0d want 1 5", s, n); end
        checks++; if (h !== 32'd0 || l !== 32'd11) begin errors++; $display("FAIL madd_result got %h:%h want 0:b", h, l); end
        do_op({6'h1C, 20'd0, 6'h04}, 32'd4, 32'd3, 32'd0, 32'd11, s, n, held, h, l);
        checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msub_result got %h:%h want ffffffff:ffffffff", h, l); end
        m_hi = h; m_lo = l;
`else
        checks++; if (s !== 1'b0 || n != 0) begin errors++; $display("FAIL madd_disabled_timing got start %b busy %0d want 0 0", s, n); end
        checks++; if (h !== 32'd0 || l !== 32'd5) begin errors++; $display("FAIL madd_disabled_hilo got %h:%h want 0:5", h, l); end
`endif
    endtask

    task automatic test_random();
        logic [5:0]  ops[8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
        logic [5:0]  f;
        logic [31:0] a, b, want, h, l;
        logic        s, held;
        int          n;
        for (int it = 0; it < 40; it++) begin
            f = ops[$urandom_range(0, 7)];
            a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            if (f == F_MFHI || f == F_MFLO) begin
                @(negedge clk);
                in_instr = special(f);
                #1 want = (f == F_MFHI) ? m_hi : m_lo;
                checks++; if (out_hilo !== want) begin errors++; $display("FAIL rand%0d_mfx got %h want %h", it, out_hilo, want); end
                in_instr = 32'd0;
            end else begin
                do_op(special(f), a, b, m_hi, m_lo, s, n, held, h, l);
                model_apply(f, a, b);
                checks++; if (s !== (exp_cycles(f) != 0) || n != exp_cycles(f) || held !== 1'b1) begin
                    errors++; $display("FAIL rand%0d_timing funct %h got start %b busy %0d held %b want busy %0d", it, f, s, n, held, exp_cycles(f));
                end
                checks++; if (h !== m_hi || l !== m_lo) begin
                    errors++; $display("FAIL rand%0d_result funct %h a %h b %h got %h:%h want %h:%h", it, f, a, b, h, l, m_hi, m_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_madd();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit; consumes the instruction and forwarded operands held in the E pipeline register and owns the architectural HI/LO registers. Multi-cycle `mult`/`multu`/`div`/`divu` run with a busy window that the hazard unit combines with the E-stage HI/LO-use flag to stall D. `mthi`/`mtlo` write HI/LO directly, and `mfhi`/`mflo` read them combinationally for the E-stage result mux.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family).
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports (one clock `clk`; `reset` is synchronous, active-high):
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous active-high reset.
- in_instr  input  32  instruction currently in E; all-zero bubble is a no-op.
- in_rs  input  32  forwarded rs operand.
- in_rt  input  32  forwarded rt operand.
- out_start  output  1  combinational; high when in_instr is a multi-cycle op accepted this cycle.
- out_busy  output  1  registered; high while an operation is in flight.
- out_hilo  output  32  combinational; HI for mfhi, LO for mflo, else 0.
- out_hi  output  32  current architectural HI.
- out_lo  output  32  current architectural LO.

## Operation
- Decode: opcode 000000 with funct MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. Any other instruction has no effect.
- State: HI, LO (32 b each); result shadows rhi, rlo; down-counter cnt (4 b); out_busy = (cnt != 0).
- Idle → Busy: out_start = multi-cycle op decoded && !out_busy. On that edge, compute into rhi/rlo and load cnt = MULT_CYCLES or DIV_CYCLES.
  - mult: signed 64-b product; multu: unsigned. rhi = [63:32], rlo = [31:0].
  - div: signed; rlo = quotient truncated toward zero, rhi = remainder with the sign of the dividend. divu: unsigned.
  - div(u) with rt == 0: the busy window runs normally, but HI/LO retain their previous values at commit.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Busy: cnt decrements each edge. On the edge where cnt == 1, HI <= rhi, LO <= rlo, cnt <= 0.
- HI/LO hold their old values throughout the busy window.
- mthi/mtlo: write HI/LO from in_rs on the edge, only when !out_busy.
- Ops decoded while busy (any multi-cycle op, mthi, mtlo) are ignored; the hazard unit guarantees they are not presented.
- mfhi/mflo while busy return the pre-operation value; stall logic prevents this case from occurring.
- Reset: HI = LO = 0, rhi = rlo = 0, cnt = 0, out_busy = 0. A reset mid-operation discards the pending result.

## Timing
- Accept at edge T0, with out_start high in the cycle before T0.
- out_busy is high for cycles T0+1 … T0+N (N = MULT_CYCLES or DIV_CYCLES).
- New HI/LO are visible from cycle T0+N+1.
- Back-to-back: a new op may be accepted in the first cycle where out_busy = 0, which is the same cycle HI/LO show the previous result.
- mthi/mtlo: latency 1; the value is visible in the cycle after the edge.
- out_hilo has zero-cycle latency from HI/LO.
- The hazard unit stalls when (out_start | out_busy) && the D-stage instruction uses HI/LO.

## Configuration
- MDU_MADD_EN defined: SPECIAL2 (opcode 0x1C) MADD funct 0x00, MADDU 0x01, MSUB 0x04 are accepted as multi-cycle ops with latency MULT_CYCLES.
  - rhi:rlo = {HI,LO} ± product; signed for MADD and MSUB, unsigned for MADDU.
  - The accumulate uses the HI/LO value at accept time.
- MDU_MADD_EN undefined: these encodings are no-ops, out_start stays low for them, and no accumulate adder is built.

## Test plan
- Reset, then mult with rs=0xFFFFFFFE (−2), rt=3:
  - out_busy high exactly 5 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle T0+6.
  - HI/LO remain 0 during the busy window.
- divu rs=7, rt=2: HI=1, LO=3 after 10 busy cycles.
- div rs=−7, rt=2: HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- div rs=0x80000000, rt=0xFFFFFFFF: LO=0x80000000, HI=0.
- div by zero after mthi 0x11 / mtlo 0x22: busy runs 10 cycles, then HI=0x11, LO=0x22.
- Mid-operation reset:
  - Start multu 0xFFFFFFFF × 0xFFFFFFFF and assert reset on busy cycle 3.
  - Next cycle: out_busy=0, HI=LO=0, and no late commit.
- With MDU_MADD_EN: HI:LO=0:5, madd 2×3 → LO=11, HI=0.
- Without MDU_MADD_EN: the same instruction gives out_start=0 and HI:LO is unchanged.
